// File: rtl/down_counter_3bit.sv
// Free-running modulo down counter with terminal count,
// wrap pulse and wrap-event counter.
module down_counter_3bit #(
  parameter int WIDTH      = 3,
  parameter int LOAD_VAL   = 2**WIDTH - 1,
  parameter int MIN_VAL    = 0,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  wrap,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] LP_LOAD = WIDTH'(LOAD_VAL);
  localparam logic [WIDTH-1:0] LP_MIN  = WIDTH'(MIN_VAL);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
    $error("down_counter_3bit: WIDTH must be 2..16");
  end

  if (MIN_VAL >= LOAD_VAL) begin : g_range_chk
    $error("down_counter_3bit: MIN_VAL must be below LOAD_VAL");
  end

  logic [WIDTH-1:0]      r_out;
  logic                  r_wrap;
  logic [WRAP_CNT_W-1:0] r_wcnt;
  logic                  w_at_min;

  assign w_at_min = (r_out == LP_MIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out  <= LP_LOAD;
      r_wrap <= 1'b0;
      r_wcnt <= '0;
    end else if (w_at_min) begin
      r_out  <= LP_LOAD;
      r_wrap <= 1'b1;
      r_wcnt <= r_wcnt + WRAP_CNT_W'(1);
    end else begin
      // forced out-of-range values fall through here too
      r_out  <= r_out - WIDTH'(1);
      r_wrap <= 1'b0;
    end
  end

  assign out        = r_out;
  assign tc         = w_at_min;
  assign wrap       = r_wrap;
  assign wrap_count = r_wcnt;

endmodule

// File: tb/tb_down_counter_3bit.sv
// Directed bench for down_counter_3bit, default and
// overridden parameter instances.
module tb_down_counter_3bit;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic [2:0] out_a;
  logic       tc_a;
  logic       wrap_a;
  logic [7:0] wc_a;
  logic [3:0] out_b;
  logic       tc_b;
  logic       wrap_b;
  logic [7:0] wc_b;

  int n_chk = 0;
  int n_err = 0;

  down_counter_3bit u_dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .out        (out_a),
    .tc         (tc_a),
    .wrap       (wrap_a),
    .wrap_count (wc_a)
  );

  down_counter_3bit #(
    .WIDTH    (4),
    .LOAD_VAL (9),
    .MIN_VAL  (2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .out        (out_b),
    .tc         (tc_b),
    .wrap       (wrap_b),
    .wrap_count (wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_a(
    input string tag,
    input int    o,
    input int    t,
    input int    w,
    input int    c
  );
    check({tag, " out"},  32'(out_a),  32'(o));
    check({tag, " tc"},   32'(tc_a),   32'(t));
    check({tag, " wrap"}, 32'(wrap_a), 32'(w));
    check({tag, " wc"},   32'(wc_a),   32'(c));
  endtask

  task automatic chk_b(
    input string tag,
    input int    o,
    input int    t,
    input int    w,
    input int    c
  );
    check({tag, " out"},  32'(out_b),  32'(o));
    check({tag, " tc"},   32'(tc_b),   32'(t));
    check({tag, " wrap"}, 32'(wrap_b), 32'(w));
    check({tag, " wc"},   32'(wc_b),   32'(c));
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;

    // test 1: reset then 6..0
    tick();
    chk_a("rst", 7, 0, 0, 0);
    rst_a = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      tick();
      chk_a($sformatf("cnt%0d", i), i,
            (i == 0) ? 1 : 0, 0, 0);
    end

    // test 2: wrap pulse and long run
    tick();
    chk_a("wrap1", 7, 0, 1, 1);
    tick();
    chk_a("post_wrap", 6, 0, 0, 1);
    repeat (100) tick();
    chk_a("run100", 2, 0, 0, 13);

    // test 3: reset at out=3
    repeat (7) tick();
    chk_a("at3", 3, 0, 0, 14);
    rst_a = 1'b0;
    tick();
    chk_a("rst_mid", 7, 0, 0, 0);
    rst_a = 1'b1;
    tick();
    chk_a("resume6", 6, 0, 0, 0);
    tick();
    chk_a("resume5", 5, 0, 0, 0);

    // test 4: reset at out=0
    repeat (5) tick();
    chk_a("at0", 0, 1, 0, 0);
    rst_a = 1'b0;
    tick();
    chk_a("rst_at0", 7, 0, 0, 0);

    // test 5: hold reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a($sformatf("hold%0d", i), 7, 0, 0, 0);
    end
    rst_a = 1'b1;
    tick();
    chk_a("release", 6, 0, 0, 0);

    // test 6: overridden instance
    tick();
    chk_b("b_rst", 9, 0, 0, 0);
    rst_b = 1'b1;
    for (int i = 8; i >= 2; i--) begin
      tick();
      chk_b($sformatf("b_cnt%0d", i), i,
            (i == 2) ? 1 : 0, 0, 0);
    end
    tick();
    chk_b("b_wrap1", 9, 0, 1, 1);
    tick();
    chk_b("b_post", 8, 0, 0, 1);
    repeat (254 * 8 - 1) tick();
    chk_b("b_wrap255", 9, 0, 1, 255);
    repeat (8) tick();
    chk_b("b_wrap256", 9, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/down_counter_3bit.md
Name: down_counter_3bit

Overview:
- Free-running synchronous modulo down counter, default 3 bits wide.
- Counts from a reload value down to a floor value, then wraps back to the reload value.
- Provides a terminal-count flag, a one-cycle wrap pulse and a wrap-event counter for downstream timing and sequencing logic.
- Port order is fixed: clk, rst, out first, so that positional instantiation with three connections stays valid.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- LOAD_VAL, 2**WIDTH-1 (7), value loaded at reset and after each wrap.
- MIN_VAL, 0, floor value; the count wraps after reaching it. Requires MIN_VAL < LOAD_VAL.
- WRAP_CNT_W, 8, width of the wrap-event counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous and active-low (asserted when 0), sampled on rising clk.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal count; combinational, high while out == MIN_VAL.
- wrap  output  1  registered one-cycle pulse, high in the cycle after out wrapped from MIN_VAL to LOAD_VAL.
- wrap_count  output  WRAP_CNT_W  number of wraps since reset; registered, modulo 2**WRAP_CNT_W.

Behaviour:
- All state updates on rising clk only. No asynchronous paths.
- Reset (rst == 0 at a rising edge):
  - out <= LOAD_VAL
  - wrap <= 0
  - wrap_count <= 0
  - Reset has priority over counting. A reset asserted mid-count takes effect at the next edge regardless of the current out value.
- Before the first reset edge, register contents are undefined. No power-up value is guaranteed.
- Counting (rst == 1):
  - If out != MIN_VAL: out <= out - 1, wrap <= 0, wrap_count unchanged.
  - If out == MIN_VAL: out <= LOAD_VAL, wrap <= 1, wrap_count <= wrap_count + 1 (wraps from all-ones to 0 without saturating).
- Latency:
  - out changes exactly one clock after each sampled edge.
  - tc follows out combinationally with no extra cycle.
  - wrap is high in the same cycle out first shows LOAD_VAL after a wrap. It is never high after reset alone.
- Period: LOAD_VAL - MIN_VAL + 1 cycles. Default sequence: 7,6,5,4,3,2,1,0,7,... (period 8).
- Out-of-range states (out < MIN_VAL or out > LOAD_VAL) are not reachable from reset. If forced, out keeps decrementing by 1 until it reaches MIN_VAL; unsigned underflow wraps modulo 2**WIDTH.
- Arithmetic:
  - Unsigned, WIDTH bits, no carry/borrow output beyond tc.
  - Parameter values are truncated to WIDTH bits.
  - An elaboration-time check flags MIN_VAL >= LOAD_VAL.
- Reset asserted in the same cycle out == MIN_VAL: reset wins. out = LOAD_VAL, wrap = 0, wrap_count = 0.
- Holding rst low for multiple cycles keeps all outputs at reset values. Counting resumes on the first edge after rst returns high, so the first post-reset value is LOAD_VAL-1.

Test Plan:
1. Clock period 10 ns, rst=0 for 1 edge, then rst=1 -> out=7 after reset, then 6,5,4,3,2,1,0 on successive edges; tc=1 only while out=0.
2. Continue from 0 -> next edge out=7, wrap=1 for exactly one cycle, wrap_count=1; after 1000 ns of counting, wrap_count = number of elapsed 8-cycle periods.
3. Assert rst=0 while out=3 -> next edge out=7, wrap=0, wrap_count=0; release -> 6,5,... resumes.
4. Assert rst=0 on the edge where out=0 -> out=7, wrap stays 0, wrap_count=0.
5. Hold rst=0 for 5 edges -> out stays 7, tc=0, wrap=0 throughout; first edge after release gives out=6.
6. Override WIDTH=4, LOAD_VAL=9, MIN_VAL=2 -> sequence 9,8,...,2,9 with period 8; tc high at 2; 256 wraps return wrap_count to 0.
